register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 116 +++++++++++
 1 files changed

// File: rtl/register_file.sv
// Architectural register file with ROB rename tags and an incrementally tracked busy count.
// Optional REGFILE_COMMIT_BYPASS_EN forwards a same-cycle commit to the read ports.
module register_file (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [4:0]  in_decoder_rs1,
   input  logic [4:0]  in_decoder_rs2,
   output logic [31:0] out_decoder_value1,
   output logic [31:0] out_decoder_value2,
   output logic [3:0]  out_decoder_tag1,
   output logic [3:0]  out_decoder_tag2,
   input  logic        in_decoder_flag,
   input  logic [4:0]  in_decoder_rd,
   input  logic [3:0]  in_decoder_rd_tag,
   input  logic [4:0]  in_rob_index,
   input  logic [3:0]  in_rob_tag,
   input  logic [31:0] in_rob_value,
   input  logic        in_rob_xbp,
   output logic [5:0]  out_busy_count
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned NREG  = 32;
   localparam int unsigned CNT_W = 6;

   logic [XLEN-1:0]  vals [NREG];
   logic [TAG_W-1:0] tags [NREG];
   logic [CNT_W-1:0] busy_count;
   logic [CNT_W-1:0] busy_count_next;

   logic commit_en;
   logic rename_en;
   logic commit_clear;
   logic inc;
   logic dec_rename;
   logic dec_commit;

   assign out_busy_count = busy_count;

   // Read port 1: stored entry, optional commit forwarding, x0 hardwired to zero
   always_comb begin
      out_decoder_value1 = vals[in_decoder_rs1];
      out_decoder_tag1   = tags[in_decoder_rs1];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (in_decoder_rs1 == in_rob_index && in_rob_index != '0 &&
          tags[in_decoder_rs1] == in_rob_tag) begin
         out_decoder_value1 = in_rob_value;
         out_decoder_tag1   = '0;
      end
`endif
      if (in_decoder_rs1 == '0) begin
         out_decoder_value1 = '0;
         out_decoder_tag1   = '0;
      end
   end

   // Read port 2: same rules as port 1
   always_comb begin
      out_decoder_value2 = vals[in_decoder_rs2];
      out_decoder_tag2   = tags[in_decoder_rs2];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (in_decoder_rs2 == in_rob_index && in_rob_index != '0 &&
          tags[in_decoder_rs2] == in_rob_tag) begin
         out_decoder_value2 = in_rob_value;
         out_decoder_tag2   = '0;
      end
`endif
      if (in_decoder_rs2 == '0) begin
         out_decoder_value2 = '0;
         out_decoder_tag2   = '0;
      end
   end

   // Update qualifiers and the busy-count delta; a rename to the committing register wins over the clear
   always_comb begin
      commit_en    = rdy && (in_rob_index != '0);
      rename_en    = rdy && in_decoder_flag && !in_rob_xbp && (in_decoder_rd != '0);
      commit_clear = commit_en && !in_rob_xbp && (tags[in_rob_index] == in_rob_tag) &&
                     !(rename_en && (in_decoder_rd == in_rob_index));
      inc          = rename_en && (tags[in_decoder_rd] == '0) && (in_decoder_rd_tag != '0);
      dec_rename   = rename_en && (tags[in_decoder_rd] != '0) && (in_decoder_rd_tag == '0);
      dec_commit   = commit_clear && (tags[in_rob_index] != '0);
      busy_count_next = busy_count + CNT_W'(inc) - CNT_W'(dec_rename) - CNT_W'(dec_commit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            vals[i] <= '0;
            tags[i] <= '0;
         end
         busy_count <= '0;
      end else if (rdy) begin
         if (commit_en) begin
            vals[in_rob_index] <= in_rob_value;
         end
         if (in_rob_xbp) begin
            for (int i = 0; i < NREG; i++) begin
               tags[i] <= '0;
            end
            busy_count <= '0;
         end else begin
            if (commit_clear) begin
               tags[in_rob_index] <= '0;
            end
            if (rename_en) begin
               tags[in_decoder_rd] <= in_decoder_rd_tag;
            end
            busy_count <= busy_count_next;
         end
      end
   end

endmodule
